// File: rtl/spi_master.sv
// SPI mode-0 byte master: one byte per cs-low window, spi_clk half-period CLK_DIV clk cycles.
// Every output comes straight from a flop so the serial pins cannot glitch.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_clk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs
);

  localparam logic [15:0] PH_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t      state_q, state_d;
  logic [15:0] ph_q, ph_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d;
  logic        spi_clk_q, spi_clk_d;
  logic        cs_q, cs_d;
  logic        ph_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      spi_clk_q  <= 1'b0;
      cs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      spi_clk_q  <= spi_clk_d;
      cs_q       <= cs_d;
    end
  end

  assign ph_last = (ph_q == PH_LAST);

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_last ? 16'd0 : ph_q + 16'd1;
    bit_d      = bit_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    spi_clk_d  = spi_clk_q;
    cs_d       = cs_q;
    case (state_q)
      IDLE: begin
        ph_d = '0;
        if (tx_valid && tx_ready_q) begin
          state_d    = SETUP;
          tx_sr_d    = tx_data;
          rx_sr_d    = '0;
          bit_d      = '0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          cs_d       = 1'b0;
        end
      end
      SETUP, LOW: begin
        if (ph_last) begin
          state_d   = HIGH;
          spi_clk_d = 1'b1;
          rx_sr_d   = {rx_sr_q[6:0], miso};
          bit_d     = bit_q + 4'd1;
        end
      end
      HIGH: begin
        if (ph_last) begin
          spi_clk_d = 1'b0;
          if (bit_q < 4'd8) begin
            state_d = LOW;
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end else begin
            // clearing the shifter parks mosi low for HOLD, GAP and IDLE
            state_d = HOLD;
            tx_sr_d = '0;
          end
        end
      end
      HOLD: begin
        if (ph_last) begin
          state_d    = GAP;
          cs_d       = 1'b1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end
      end
      GAP: begin
        if (ph_last) begin
          state_d    = IDLE;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        ph_d       = '0;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        spi_clk_d  = 1'b0;
        cs_d       = 1'b1;
      end
    endcase
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign spi_clk  = spi_clk_q;
  assign mosi     = tx_sr_q[7];
  assign cs       = cs_q;

endmodule
